uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter: per-requester byte
// handshake plus the grant/lock status the arbiter reports back.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   grant;
  logic              locked;
  logic              lock_drop;

  // Producers drive bytes and observe acks/grant.
  modport master (
    output req_valid, req_data, req_last,
    input  req_ack, grant, locked, lock_drop
  );

  // The arbiter consumes bytes and reports ownership.
  modport slave (
    input  req_valid, req_data, req_last,
    output req_ack, grant, locked, lock_drop
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one buart transmit channel between NREQ byte
// producers. One byte per grant; a byte with req_last=0 locks the channel
// to its owner until a req_last=1 byte or an idle timeout releases it.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int GUARD        = 1,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic               uart_wr,
  output logic [7:0]         uart_data,
  input  logic               uart_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEND   = 2'd1,
    S_STROBE = 2'd2,
    S_GUARD  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [PW-1:0]     ptr_r, ptr_s;
  logic              locked_r, locked_s;
  logic              last_r, last_s;
  logic [3:0]        guard_r, guard_s;
  logic [15:0]       tmo_r, tmo_s;
  logic [NREQ-1:0]   req_ack_r, req_ack_s;
  logic [NREQ-1:0]   grant_r, grant_s;
  logic              lock_drop_r, lock_drop_s;
  logic              uart_wr_r, uart_wr_s;
  logic [7:0]        uart_data_r, uart_data_s;

  logic              found_s;
  logic [PW-1:0]     pick_s;
  logic [PW-1:0]     cand_s;

  function automatic logic [NREQ-1:0] onehot_f(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pick the eligible requester: the lock owner only, or the first valid one after the pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_r;
    cand_s  = ptr_r;
    if (locked_r) begin
      found_s = bus.req_valid[ptr_r];
      pick_s  = ptr_r;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        cand_s = PW'((int'(ptr_r) + k) % NREQ);
        if (!found_s && bus.req_valid[cand_s]) begin
          found_s = 1'b1;
          pick_s  = cand_s;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Next-state and next-output logic of the transmit FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    locked_s    = locked_r;
    last_s      = last_r;
    guard_s     = guard_r;
    tmo_s       = tmo_r;
    req_ack_s   = {NREQ{1'b0}};
    grant_s     = grant_r;
    lock_drop_s = 1'b0;
    uart_wr_s   = 1'b0;
    uart_data_s = uart_data_r;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          uart_data_s = bus.req_data[{pick_s, 3'b000} +: 8];
          last_s      = bus.req_last[pick_s];
          req_ack_s   = onehot_f(pick_s);
          grant_s     = onehot_f(pick_s);
          ptr_s       = pick_s;
          tmo_s       = 16'd0;
          state_s     = S_SEND;
        end else if (locked_r) begin
          // Owner is idle while holding the lock: count towards forced release.
          if (tmo_r == 16'(LOCK_TIMEOUT - 1)) begin
            locked_s    = 1'b0;
            lock_drop_s = 1'b1;
            grant_s     = {NREQ{1'b0}};
            tmo_s       = 16'd0;
          end else begin
            tmo_s = tmo_r + 16'd1;
          end
        end else begin
          grant_s = {NREQ{1'b0}};
        end
      end
      S_SEND: begin
        if (!uart_busy) begin
          uart_wr_s = 1'b1;
          state_s   = S_STROBE;
        end else begin
          state_s = S_SEND;
        end
      end
      S_STROBE: begin
        locked_s = !last_r;
        if (GUARD == 0) begin
          state_s = S_IDLE;
        end else begin
          guard_s = 4'(GUARD);
          state_s = S_GUARD;
        end
      end
      S_GUARD: begin
        guard_s = guard_r - 4'd1;
        if (guard_r == 4'd1) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_GUARD;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any byte in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      ptr_r       <= PW'(NREQ - 1);
      locked_r    <= 1'b0;
      last_r      <= 1'b0;
      guard_r     <= 4'd0;
      tmo_r       <= 16'd0;
      req_ack_r   <= {NREQ{1'b0}};
      grant_r     <= {NREQ{1'b0}};
      lock_drop_r <= 1'b0;
      uart_wr_r   <= 1'b0;
      uart_data_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      locked_r    <= locked_s;
      last_r      <= last_s;
      guard_r     <= guard_s;
      tmo_r       <= tmo_s;
      req_ack_r   <= req_ack_s;
      grant_r     <= grant_s;
      lock_drop_r <= lock_drop_s;
      uart_wr_r   <= uart_wr_s;
      uart_data_r <= uart_data_s;
    end
  end

  assign bus.req_ack   = req_ack_r;
  assign bus.grant     = grant_r;
  assign bus.locked    = locked_r;
  assign bus.lock_drop = lock_drop_r;
  assign uart_wr       = uart_wr_r;
  assign uart_data     = uart_data_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios and random
// traffic, all checked every cycle against a timeline-based reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int GUARD = 1;
  localparam int LT    = 8;

  logic       clk;
  logic       reset;
  logic       uart_wr;
  logic [7:0] uart_data;
  logic       uart_busy;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .GUARD(GUARD), .LOCK_TIMEOUT(LT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .uart_wr   (uart_wr),
    .uart_data (uart_data),
    .uart_busy (uart_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Producer side: per-requester queue of {last, data}.
  logic [8:0]      q [NREQ][$];
  logic [NREQ-1:0] gate;
  logic [NREQ-1:0] ack_seen;
  logic [7:0]      obs [$];
  int              n_drop = 0;
  bit              rnd = 1'b0;

  // Reference model state (plain integers and cycle stamps).
  int              cyc = 0;
  bit              have_pred = 1'b0;
  int              m_ptr, m_owner, m_powner, m_tmo, m_idle_from, m_lock_at;
  bit              m_locked, m_pend, m_plast;
  logic [NREQ-1:0] p_ack, p_grant;
  logic            p_locked, p_drop, p_wr;
  logic [7:0]      p_data;

  // Checker: compare last prediction, then predict the next cycle from current inputs.
  initial begin
    forever begin
      @(negedge clk);
      if (have_pred) begin
        check_eq("req_ack",   bus.req_ack,   p_ack);
        check_eq("grant",     bus.grant,     p_grant);
        check_eq("locked",    bus.locked,    p_locked);
        check_eq("lock_drop", bus.lock_drop, p_drop);
        check_eq("uart_wr",   uart_wr,       p_wr);
        check_eq("uart_data", uart_data,     p_data);
      end
      if (uart_wr === 1'b1) obs.push_back(uart_data);
      if (bus.lock_drop === 1'b1) n_drop++;
      p_ack  = '0;
      p_wr   = 1'b0;
      p_drop = 1'b0;
      if (reset) begin
        p_grant = '0; p_locked = 1'b0; p_data = 8'h00;
        m_ptr = NREQ - 1; m_locked = 1'b0; m_pend = 1'b0; m_tmo = 0;
        m_idle_from = cyc + 1; m_lock_at = -1;
      end else if (m_pend) begin
        if (!uart_busy) begin
          p_wr = 1'b1;
          m_pend = 1'b0;
          m_lock_at = cyc + 1;
          m_idle_from = cyc + 2 + GUARD;
        end
      end else if (cyc == m_lock_at) begin
        m_locked = !m_plast;
        m_owner  = m_powner;
        m_tmo    = 0;
        p_locked = m_locked;
      end else if (cyc >= m_idle_from) begin
        int pick;
        pick = -1;
        if (m_locked) begin
          if (bus.req_valid[m_owner]) pick = m_owner;
          else begin
            m_tmo++;
            if (m_tmo == LT) begin
              m_locked = 1'b0; p_locked = 1'b0; p_drop = 1'b1; p_grant = '0; m_tmo = 0;
            end
          end
        end else begin
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (pick < 0 && bus.req_valid[c]) pick = c;
          end
          if (pick < 0) p_grant = '0;
        end
        if (pick >= 0) begin
          p_ack       = NREQ'(1) << pick;
          p_grant     = NREQ'(1) << pick;
          p_data      = bus.req_data[8*pick +: 8];
          m_ptr       = pick;
          m_pend      = 1'b1;
          m_plast     = bus.req_last[pick];
          m_powner    = pick;
          m_tmo       = 0;
          m_idle_from = 1 << 30;
        end
      end
      have_pred = 1'b1;
      cyc++;
    end
  end

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of stimulus: retire acked bytes, randomize if enabled, drive the bus.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (ack_seen[i] && q[i].size() != 0) void'(q[i].pop_front());
    ack_seen = bus.req_ack;
    if (rnd) begin
      uart_busy = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NREQ; i++) begin
        gate[i] = ($urandom_range(0, 7) == 0);
        if (q[i].size() < 2 && $urandom_range(0, 3) == 0)
          q[i].push_back({($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom)});
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]        = (q[i].size() != 0) && !gate[i];
      bus.req_data[8*i +: 8]  = (q[i].size() != 0) ? q[i][0][7:0] : 8'h00;
      bus.req_last[i]         = (q[i].size() != 0) ? q[i][0][8] : 1'b0;
    end
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!queues_empty() && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_drained"}, queues_empty(), 1);
    repeat (12) step();
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp [$]);
    check_eq({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check_eq({tag, "_byte"}, obs[i], exp[i]);
  endtask

  initial begin
    int n;
    logic [7:0] exp [$];
    int drops0;
    reset = 1'b1;
    uart_busy = 1'b0;
    gate = '0;
    ack_seen = '0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Round-robin fairness from reset: requester 0 first.
    obs.delete();
    for (int i = 0; i < NREQ; i++) q[i].push_back({1'b1, 8'(8'h41 + i)});
    run_drain("fair", 60);
    exp = '{8'h41, 8'h42, 8'h43, 8'h44};
    check_stream("fair", exp);

    // Backpressure: busy high for 20 cycles.
    obs.delete();
    q[1].push_back({1'b1, 8'h55});
    uart_busy = 1'b1;
    repeat (20) step();
    uart_busy = 1'b0;
    run_drain("bp", 40);
    exp = '{8'h55};
    check_stream("bp", exp);

    // Message lock: req2 "Hi" must not be interleaved by req0.
    obs.delete();
    q[2].push_back({1'b0, 8'h48});
    q[2].push_back({1'b1, 8'h69});
    n = 0;
    while (bus.req_ack[2] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq("lock_first_ack", bus.req_ack[2], 1);
    q[0].push_back({1'b1, 8'h30});
    run_drain("lock", 60);
    exp = '{8'h48, 8'h69, 8'h30};
    check_stream("lock", exp);

    // Lock timeout: req3 locks then goes silent.
    obs.delete();
    drops0 = n_drop;
    q[3].push_back({1'b0, 8'h01});
    q[0].push_back({1'b1, 8'h02});
    run_drain("tmo", 80);
    exp = '{8'h01, 8'h02};
    check_stream("tmo", exp);
    check_eq("tmo_drop_count", n_drop - drops0, 1);

    // Random traffic with busy, dropped valids, locks and mid-run resets.
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    reset = 1'b0;
    uart_busy = 1'b0;
    gate = '0;
    run_drain("rand", 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
